// File: rtl/io_cmd_pkg.sv
// Shared types and byte constants for the I/O-bus command engine.
// The IOCMD_TIMEOUT_EN build uses RSP_TMO; the default build does not.
package io_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StStrobe,
        StWait,
        StResp
    } state_e;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_TMO = 8'h54;
    localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/io_cmd_if.sv
// Byte-stream and MCS I/O-bus signals of the command engine.
// The master modport is the engine side; the slave modport is the host link and responder side.
interface io_cmd_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready, io_read_data, io_ready,
        output rx_ready, tx_data, tx_valid, io_addr_strobe, io_read_strobe,
               io_write_strobe, io_byte_enable, io_address, io_write_data
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, io_read_data, io_ready,
        input  rx_ready, tx_data, tx_valid, io_addr_strobe, io_read_strobe,
               io_write_strobe, io_byte_enable, io_address, io_write_data
    );

endinterface

// File: rtl/io_cmd_watchdog.sv
// Cycle counter that flags expiry on the TIMEOUT-th enabled cycle after a clear.
// Instantiated by io_cmd_master only when IOCMD_TIMEOUT_EN is defined.
module io_cmd_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/io_cmd_master.sv
// Byte-stream command engine acting as initiator on the MCS I/O bus.
// Optional watchdog (0x54 response) is compiled in with IOCMD_TIMEOUT_EN.
module io_cmd_master
    import io_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input logic       clk,
    input logic       reset_n,
    io_cmd_if.master  bus
);

    state_e      state;
    logic        is_wr;
    logic [1:0]  cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [23:0] rdata;
    logic [7:0]  tx_byte;
    logic        addr_stb;
    logic        rd_stb;
    logic        wr_stb;
    logic [3:0]  be;

`ifdef IOCMD_TIMEOUT_EN
    logic expired;

    io_cmd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == StStrobe),
        .enable  (state == StWait),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            is_wr    <= 1'b0;
            cnt      <= 2'd0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            tx_byte  <= '0;
            addr_stb <= 1'b0;
            rd_stb   <= 1'b0;
            wr_stb   <= 1'b0;
            be       <= 4'h0;
        end else begin
            addr_stb <= 1'b0;
            rd_stb   <= 1'b0;
            wr_stb   <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.rx_valid) begin
                        cnt <= 2'd0;
                        if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
                            is_wr <= (bus.rx_data == OP_WR);
                            state <= StAddr;
                        end else begin
                            tx_byte <= RSP_ERR;
                            state   <= StResp;
                        end
                    end
                end
                StAddr: begin
                    if (bus.rx_valid) begin
                        addr <= {addr[23:0], bus.rx_data};
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_wr) begin
                                state <= StData;
                            end else begin
                                state    <= StStrobe;
                                addr_stb <= 1'b1;
                                rd_stb   <= 1'b1;
                                be       <= 4'hf;
                            end
                        end
                    end
                end
                StData: begin
                    if (bus.rx_valid) begin
                        wdata <= {wdata[23:0], bus.rx_data};
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state    <= StStrobe;
                            addr_stb <= 1'b1;
                            wr_stb   <= 1'b1;
                            be       <= 4'hf;
                        end
                    end
                end
                StStrobe: begin
                    state <= StWait;
                end
                StWait: begin
                    // io_ready takes priority over an expiring watchdog in the same cycle
                    if (bus.io_ready) begin
                        be    <= 4'h0;
                        state <= StResp;
                        if (is_wr) begin
                            tx_byte <= RSP_ACK;
                            cnt     <= 2'd0;
                        end else begin
                            tx_byte <= bus.io_read_data[31:24];
                            rdata   <= bus.io_read_data[23:0];
                            cnt     <= 2'd3;
                        end
                    end
`ifdef IOCMD_TIMEOUT_EN
                    else if (expired) begin
                        be      <= 4'h0;
                        tx_byte <= RSP_TMO;
                        cnt     <= 2'd0;
                        state   <= StResp;
                    end
`endif
                end
                StResp: begin
                    // cnt holds the number of bytes still to follow the one on tx_data
                    if (bus.tx_ready) begin
                        if (cnt == 2'd0) begin
                            state <= StIdle;
                        end else begin
                            cnt     <= cnt - 2'd1;
                            tx_byte <= rdata[23:16];
                            rdata   <= {rdata[15:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.rx_ready        = (state == StIdle) || (state == StAddr) || (state == StData);
    assign bus.tx_valid        = (state == StResp);
    assign bus.tx_data         = tx_byte;
    assign bus.io_addr_strobe  = addr_stb;
    assign bus.io_read_strobe  = rd_stb;
    assign bus.io_write_strobe = wr_stb;
    assign bus.io_byte_enable  = be;
    assign bus.io_address      = addr;
    assign bus.io_write_data   = wdata;

endmodule

// File: tb/tb_io_cmd_master.sv
// Directed testbench for io_cmd_master; the timeout scenario runs when IOCMD_TIMEOUT_EN is defined.
module tb_io_cmd_master;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    io_cmd_if bus();

    io_cmd_master #(
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_rx_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled mid-cycle
    int stb_cnt = 0, wr_cnt = 0, rd_cnt = 0, stb_cyc = 0, tx_cycles = 0;
    logic [31:0] stb_addr = '0, stb_wdata = '0, rdy_addr = '0;
    logic [3:0]  stb_be = '0, rdy_be = '0;

    always @(negedge clk) begin
        if (bus.io_addr_strobe) begin
            stb_cnt   <= stb_cnt + 1;
            stb_cyc   <= cyc;
            stb_addr  <= bus.io_address;
            stb_wdata <= bus.io_write_data;
            stb_be    <= bus.io_byte_enable;
        end
        if (bus.io_write_strobe) wr_cnt <= wr_cnt + 1;
        if (bus.io_read_strobe) rd_cnt <= rd_cnt + 1;
        if (bus.tx_valid) tx_cycles <= tx_cycles + 1;
        if (bus.io_ready) begin
            rdy_addr <= bus.io_address;
            rdy_be   <= bus.io_byte_enable;
        end
    end

    // Responder: io_ready pulses resp_delay cycles after the strobe cycle
    logic        resp_en = 1'b0;
    int          resp_delay = 1;
    logic [31:0] resp_data = '0;

    initial begin
        bus.io_ready     = 1'b0;
        bus.io_read_data = '0;
        forever begin
            @(negedge clk);
            if (bus.io_addr_strobe && resp_en) begin
                repeat (resp_delay) @(posedge clk);
                #1;
                bus.io_ready     = 1'b1;
                bus.io_read_data = resp_data;
                @(posedge clk);
                #1;
                bus.io_ready = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            total++; bad++;
            $display("FAIL rx_accept: rx_ready=0 after %0d cycles, required 1", n);
        end else begin
            last_rx_cyc = cyc;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output int c);
        int n;
        n = 0;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_valid) begin
            total++; bad++;
            $display("FAIL tx_wait: tx_valid=0 after %0d cycles, required 1", n);
            b = 8'h00;
            c = -1;
        end else begin
            b = bus.tx_data;
            c = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rd(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        total++; if ({bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes: got %b want 000",
                            {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe});
        end
        total++; if (bus.io_byte_enable !== 4'h0) begin bad++; $display("FAIL reset_be: got %h want 0", bus.io_byte_enable); end
        total++; if (bus.io_address !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.io_address); end
        total++; if (bus.io_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus.io_write_data); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_write;
        int s0, w0, r0, c;
        logic [7:0] b;
        s0 = stb_cnt; w0 = wr_cnt; r0 = rd_cnt;
        resp_delay = 2;
        send_wr(32'hC000_0004, 32'h1234_5678);
        recv_byte(b, c);
        total++; if (b !== 8'h4B) begin bad++; $display("FAIL wr_ack: got %h want 4b", b); end
        total++; if (stb_cnt - s0 !== 1) begin bad++; $display("FAIL wr_addr_strobe_cycles: got %0d want 1", stb_cnt - s0); end
        total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wr_write_strobe: got %0d want 1", wr_cnt - w0); end
        total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL wr_read_strobe: got %0d want 0", rd_cnt - r0); end
        total++; if (stb_addr !== 32'hC000_0004) begin bad++; $display("FAIL wr_addr: got %h want c0000004", stb_addr); end
        total++; if (stb_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_data: got %h want 12345678", stb_wdata); end
        total++; if (stb_be !== 4'hf) begin bad++; $display("FAIL wr_be: got %h want f", stb_be); end
        total++; if (stb_cyc !== last_rx_cyc + 1) begin bad++; $display("FAIL wr_strobe_time: got %0d want %0d", stb_cyc, last_rx_cyc + 1); end
        total++; if (rdy_addr !== 32'hC000_0004 || rdy_be !== 4'hf) begin
            bad++; $display("FAIL wr_wait_hold: got addr %h be %h want c0000004 f", rdy_addr, rdy_be);
        end
        total++; if (c !== stb_cyc + 3) begin bad++; $display("FAIL wr_ack_time: got %0d want %0d", c, stb_cyc + 3); end
    endtask

    task automatic test_read;
        int r0, w0, c0, c;
        logic [7:0] b;
        logic [31:0] exp;
        r0 = rd_cnt; w0 = wr_cnt;
        exp = 32'hDEAD_BEEF;
        resp_delay = 1;
        resp_data = 32'hDEAD_BEEF;
        send_rd(32'hC000_0008);
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, c);
            if (i == 0) c0 = c;
            total++; if (b !== exp[31-8*i -: 8]) begin bad++; $display("FAIL rd_byte%0d: got %h want %h", i, b, exp[31-8*i -: 8]); end
            total++; if (c !== c0 + i) begin bad++; $display("FAIL rd_byte%0d_time: got %0d want %0d", i, c, c0 + i); end
        end
        total++; if (c0 !== last_rx_cyc + 3) begin bad++; $display("FAIL rd_latency: got %0d want %0d", c0 - last_rx_cyc, 3); end
        total++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
            bad++; $display("FAIL rd_strobes: got rd %0d wr %0d want rd 1 wr 0", rd_cnt - r0, wr_cnt - w0);
        end
        total++; if (stb_addr !== 32'hC000_0008) begin bad++; $display("FAIL rd_addr: got %h want c0000008", stb_addr); end
    endtask

    task automatic test_bad_opcode;
        int s0, c;
        logic [7:0] b;
        s0 = stb_cnt;
        send_byte(8'h41);
        recv_byte(b, c);
        total++; if (b !== 8'h45) begin bad++; $display("FAIL bad_op_resp: got %h want 45", b); end
        total++; if (c !== last_rx_cyc + 1) begin bad++; $display("FAIL bad_op_time: got %0d want %0d", c, last_rx_cyc + 1); end
        @(negedge clk);
        total++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            bad++; $display("FAIL bad_op_return: got rx_ready %b tx_valid %b want 1 0", bus.rx_ready, bus.tx_valid);
        end
        total++; if (stb_cnt !== s0) begin bad++; $display("FAIL bad_op_strobe: got %0d strobes want 0", stb_cnt - s0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int n, c;
        logic [7:0] b;
        logic [31:0] exp;
        exp = 32'hDEAD_BEEF;
        resp_delay = 1;
        resp_data = 32'hDEAD_BEEF;
        bus.tx_ready = 1'b0;
        send_rd(32'h0000_000C);
        n = 0;
        @(negedge clk);
        while (!bus.tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hDE) begin
                bad++; $display("FAIL bp_hold%0d: got valid %b data %h want 1 de", i, bus.tx_valid, bus.tx_data);
            end
            total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL bp_rx_ready%0d: got %b want 0", i, bus.rx_ready); end
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, c);
            total++; if (b !== exp[31-8*i -: 8]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, b, exp[31-8*i -: 8]); end
            total++; if (bus.rx_ready !== (i == 3)) begin
                bad++; $display("FAIL bp_rx_after%0d: got %b want %b", i, bus.rx_ready, i == 3);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int t0, c;
        logic [7:0] b;
        resp_delay = 8;
        t0 = tx_cycles;
        send_rd(32'h0000_0010);
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.io_byte_enable !== 4'hf) begin bad++; $display("FAIL rst_wait_be: got %h want f", bus.io_byte_enable); end
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            bad++; $display("FAIL rst_async_flow: got rx_ready %b tx_valid %b want 1 0", bus.rx_ready, bus.tx_valid);
        end
        total++; if (bus.io_byte_enable !== 4'h0 || bus.io_addr_strobe !== 1'b0) begin
            bad++; $display("FAIL rst_async_bus: got be %h stb %b want 0 0", bus.io_byte_enable, bus.io_addr_strobe);
        end
        total++; if (bus.io_address !== 32'h0 || bus.io_write_data !== 32'h0) begin
            bad++; $display("FAIL rst_async_regs: got addr %h wdata %h want 0 0", bus.io_address, bus.io_write_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++; if (tx_cycles !== t0) begin bad++; $display("FAIL rst_no_tx: got %0d tx cycles want 0", tx_cycles - t0); end
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rst_late_ready: got rx_ready %b want 1", bus.rx_ready); end
        resp_delay = 1;
        send_wr(32'h1020_3040, 32'h0A0B_0C0D);
        recv_byte(b, c);
        total++; if (b !== 8'h4B) begin bad++; $display("FAIL rst_next_ack: got %h want 4b", b); end
        total++; if (stb_wdata !== 32'h0A0B_0C0D) begin bad++; $display("FAIL rst_next_data: got %h want 0a0b0c0d", stb_wdata); end
    endtask

`ifdef IOCMD_TIMEOUT_EN
    task automatic test_timeout;
        int t0, c;
        logic [7:0] b;
        resp_delay = 20;
        send_rd(32'h0000_0014);
        recv_byte(b, c);
        total++; if (b !== 8'h54) begin bad++; $display("FAIL tmo_resp: got %h want 54", b); end
        total++; if (c !== stb_cyc + 17) begin bad++; $display("FAIL tmo_time: got %0d want %0d", c, stb_cyc + 17); end
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            bad++; $display("FAIL tmo_single: got tx_valid %b rx_ready %b want 0 1", bus.tx_valid, bus.rx_ready);
        end
        t0 = tx_cycles;
        repeat (6) @(posedge clk);
        #1;
        total++; if (tx_cycles !== t0) begin bad++; $display("FAIL tmo_late_ready: got %0d tx cycles want 0", tx_cycles - t0); end
        resp_delay = 1;
        send_wr(32'h0000_0018, 32'h5555_AAAA);
        recv_byte(b, c);
        total++; if (b !== 8'h4B) begin bad++; $display("FAIL tmo_next_ack: got %h want 4b", b); end
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        resp_en      = 1'b1;
        test_reset;
        test_write;
        test_read;
        test_bad_opcode;
        test_backpressure;
        test_reset_mid_wait;
`ifdef IOCMD_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_cmd_master.md
# io_cmd_master

Byte-stream command engine that acts as initiator on the MicroBlaze MCS I/O bus. It sits where the CPU normally sits in front of `chu_mcs_bridge`, so a host link (UART rx/tx FIFOs) can peek and poke FPro MMIO and video registers without firmware. It decodes read and write command frames from an input byte stream, issues one strobed I/O-bus transaction per frame, waits for `io_ready`, and returns an ack or read data on an output byte stream.

## Interface
- `TIMEOUT`, default 1023: number of cycles to wait for `io_ready` before aborting. Used only with the watchdog enabled.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: command byte.
- `rx_valid`, input, 1: `rx_data` is valid.
- `rx_ready`, output, 1: engine accepts a byte; a byte transfers when `rx_valid && rx_ready`.
- `tx_data`, output, 8: response byte.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: sink accepts the byte; a byte transfers when `tx_valid && tx_ready`.
- `io_addr_strobe`, output, 1: one-cycle transaction pulse.
- `io_read_strobe`, output, 1: one-cycle read pulse.
- `io_write_strobe`, output, 1: one-cycle write pulse.
- `io_byte_enable`, output, 4: always 4'hf during a transaction.
- `io_address`, output, 32: transaction address.
- `io_write_data`, output, 32: write data.
- `io_read_data`, input, 32: read data, valid while `io_ready` is high.
- `io_ready`, input, 1: one-cycle completion pulse from the responder.

## Operation
- Command frames:
  - Write: 0x57, then 4 address bytes MSB first, then 4 data bytes MSB first.
  - Read: 0x52, then 4 address bytes MSB first.
- Responses:
  - Write success: 0x4B.
  - Read success: 4 data bytes, MSB first.
  - Timeout: 0x54.
  - Unknown opcode: 0x45.
- States:
  - IDLE: accept opcode. 0x57 or 0x52 → ADDR; any other byte → RESP with 0x45. The bad byte is consumed and no bus activity occurs.
  - ADDR: accept 4 address bytes with a 2-bit counter. After byte 3: write → DATA, read → STROBE.
  - DATA: accept 4 data bytes. After byte 3 → STROBE.
  - STROBE: exactly one cycle. `io_addr_strobe` is high, plus `io_write_strobe` or `io_read_strobe` according to the opcode. → WAIT.
  - WAIT: hold `io_address`, `io_write_data` and `io_byte_enable` stable. On `io_ready`, capture `io_read_data` for a read and → RESP. With the watchdog enabled, reaching the timeout → RESP with 0x54.
  - RESP: present response bytes in order. After the last byte's handshake → IDLE.
- `rx_ready` is high exactly in IDLE, ADDR and DATA; it is decoded from the state.
- `tx_valid` is high exactly in RESP. `tx_data` is stable while `tx_valid && !tx_ready`.
- `io_ready` is ignored outside WAIT, including an `io_ready` that arrives in the STROBE cycle.
- Reset values:
  - State is IDLE, so `rx_ready` = 1.
  - All strobes = 0; `io_byte_enable` = 0.
  - `io_address`, `io_write_data` and `tx_data` = 0; `tx_valid` = 0.
  - Counters = 0.
- Asserting reset mid-frame or mid-WAIT aborts the transaction silently: no response byte is sent and any late `io_ready` is ignored.

## Timing
- A byte accepted on cycle n updates the state at the edge ending cycle n.
- The last command byte is accepted on cycle n; STROBE follows on n+1.
- `io_ready` sampled on cycle m (m ≥ n+2) → `tx_valid` is high on m+1.
- Byte k+1 of a response appears the cycle after byte k's handshake. With `tx_ready` held high, a read response takes 4 consecutive cycles.
- After the final response handshake on cycle p, `rx_ready` is high on p+1.
- Zero-wait read, end to end, from the last rx byte to the first tx byte: 3 cycles.
- Timeout:
  - The counter clears on entry to WAIT and increments every WAIT cycle.
  - When the counter equals TIMEOUT−1 and `io_ready` is low, the next state is RESP(0x54). A timed-out read returns only 0x54.
  - `io_ready` and the timeout in the same cycle: `io_ready` wins.

## Configuration
- `IOCMD_TIMEOUT_EN`:
  - Defined: the watchdog is compiled in and the 0x54 response exists.
  - Undefined: WAIT waits for `io_ready` indefinitely, the `TIMEOUT` parameter has no effect, and no counter logic is generated.

## Structure
- Shared package `io_cmd_pkg` holds:
  - the state enum;
  - the opcode constants `OP_WR` = 8'h57 and `OP_RD` = 8'h52;
  - the response constants `RSP_ACK` = 8'h4B, `RSP_TMO` = 8'h54 and `RSP_ERR` = 8'h45.
- One sub-module, `io_cmd_watchdog`:
  - Inputs: `clk`, `reset_n`, `clear`, `enable`.
  - Output: `expired`.
  - Parameter: `TIMEOUT`; counter width is $clog2(TIMEOUT).
  - Instantiated only under `IOCMD_TIMEOUT_EN`.

## Test plan
1. **Write:** send 57 C0 00 00 04 12 34 56 78; responder gives `io_ready` 2 cycles after the strobe → one cycle with `io_write_strobe` = 1, `io_address` = C000_0004, `io_write_data` = 1234_5678 and `io_byte_enable` = F; then tx 4B.
2. **Read:** send 52 C0 00 00 08; responder returns DEAD_BEEF with zero wait → `io_read_strobe` pulse, then tx DE AD BE EF; the first tx byte comes 3 cycles after the last rx byte.
3. **Bad opcode:** send 41 → tx 45; no strobe; `rx_ready` is high again the cycle after the 45 handshake.
4. **Timeout:** with `IOCMD_TIMEOUT_EN` and TIMEOUT = 16, send a read with no `io_ready` → tx 54 after 16 WAIT cycles; a late `io_ready` is ignored and the next command works.
5. **Backpressure:** during a read response, hold `tx_ready` low for 5 cycles → `tx_data` is held at DE and byte order is preserved; `rx_ready` stays low until the last byte.
6. **Reset mid-WAIT:** pulse `reset_n` low during WAIT → all outputs take their reset values immediately (asynchronous); no tx byte is sent; a following write completes normally.
